fetch_ctrl: RTL and testbench

- Instruction-fetch sequencer for the pipelined MIPS core; owns the fetch PC and drives a synchronous-read word-indexed instruction memory (Im_Addr_Out → Im_Instr_In, 1-cycle read latency).
- Buffers returned words in a 2-entry queue and hands them to decode over a valid/ready handshake.
- Accepts a redirect (branch/jump/exception target) that discards all stale fetches.

---
 rtl/fetch_pkg.sv | 17 +
 rtl/fetch_queue.sv | 43 ++++
 rtl/fetch_ctrl.sv | 108 ++++++++++
 tb/tb_fetch_ctrl.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
package fetch_pkg;

  localparam logic [31:0] IM_BASE_DEF  = 32'h0000_3000;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;
  localparam int          ADDR_W_DEF   = 12;
  localparam logic [31:0] NOP          = 32'h0000_0000;
  localparam int          QUEUE_DEPTH  = 2;

  // One fetched word on its way to decode.
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        exc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Two-entry FIFO of fetch entries between instruction memory and decode.
// Flush wins over push and pop; push and pop together are legal when full.
module fetch_queue
  import fetch_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  fetch_entry_t din,
  input  logic         pop,
  input  logic         flush,
  output fetch_entry_t head,
  output logic [1:0]   count
);

  fetch_entry_t mem [QUEUE_DEPTH];
  logic         rd_ptr;
  logic         wr_ptr;

  // Storage, pointers and occupancy; the caller guarantees no overflow/underflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < QUEUE_DEPTH; i++) mem[i] <= '0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (flush) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the fetch PC, strobes a 1-cycle-latency
// instruction memory and feeds decode through a 2-entry queue.
// Optional: define FETCH_CTRL_ADDR_EXC_EN to flag misaligned or out-of-range
// fetch addresses as exception entries and halt fetch until redirect/reset.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter logic [31:0] IM_BASE  = IM_BASE_DEF,
  parameter int          ADDR_W   = ADDR_W_DEF
) (
  input  logic              Clk,
  input  logic              Reset,
  output logic              Im_En_Out,
  output logic [ADDR_W-1:0] Im_Addr_Out,
  input  logic [31:0]       Im_Instr_In,
  output logic [31:0]       Instr_Out,
  output logic [31:0]       Pc_Out,
  output logic              Instr_Valid_Out,
  input  logic              Dec_Ready_In,
  input  logic              Redirect_In,
  input  logic [31:0]       Redirect_Pc_In,
  output logic              Exc_Out
);

  logic [31:0]  fetch_pc;
  logic [31:0]  inflight_pc;
  logic [31:0]  pc_off;
  logic         inflight;
  logic         inflight_exc;
  logic         halted;
  logic         pop;
  logic         room;
  logic         issue;
  logic         addr_bad;
  logic [2:0]   occ;
  logic [1:0]   q_count;
  fetch_entry_t q_din;
  fetch_entry_t q_head;

  assign pc_off      = fetch_pc - IM_BASE;
  assign Im_Addr_Out = ADDR_W'(pc_off >> 2);

`ifdef FETCH_CTRL_ADDR_EXC_EN
  // Misaligned, or outside the memory window (below-base wraps to a huge offset).
  assign addr_bad = (fetch_pc[1:0] != 2'b00) | (pc_off[31:ADDR_W+2] != '0);
`else
  assign addr_bad = 1'b0;
`endif

  assign Instr_Valid_Out = (q_count != 2'd0);
  assign pop             = Instr_Valid_Out & Dec_Ready_In;

  // Issue only when the queue can still hold this read after the pending one lands.
  always_comb begin
    occ   = {1'b0, q_count} + {2'b0, inflight};
    room  = occ < (3'd2 + {2'b0, pop});
    issue = ~Reset & ~Redirect_In & ~halted & room;
  end

  // A faulting issue occupies the in-flight slot but never touches memory.
  assign Im_En_Out = issue & ~addr_bad;

  // Fetch PC, in-flight read tracking and the fault halt.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      fetch_pc     <= RESET_PC;
      inflight     <= 1'b0;
      inflight_pc  <= '0;
      inflight_exc <= 1'b0;
      halted       <= 1'b0;
    end else if (Redirect_In) begin
      fetch_pc     <= Redirect_Pc_In;
      inflight     <= 1'b0;
      inflight_exc <= 1'b0;
      halted       <= 1'b0;
    end else begin
      inflight <= issue;
      if (issue) begin
        inflight_pc  <= fetch_pc;
        inflight_exc <= addr_bad;
        fetch_pc     <= fetch_pc + 32'd4;
        if (addr_bad) halted <= 1'b1;
      end
    end
  end

  assign q_din = '{instr: (inflight_exc ? NOP : Im_Instr_In),
                   pc:    inflight_pc,
                   exc:   inflight_exc};

  // Redirect flushes the queue; the read returning in that cycle is stale too.
  fetch_queue u_queue (
    .clk   (Clk),
    .rst   (Reset),
    .push  (inflight),
    .din   (q_din),
    .pop   (pop),
    .flush (Redirect_In),
    .head  (q_head),
    .count (q_count)
  );

  assign Instr_Out = Instr_Valid_Out ? q_head.instr : '0;
  assign Pc_Out    = Instr_Valid_Out ? q_head.pc    : '0;
  assign Exc_Out   = Instr_Valid_Out & q_head.exc;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed vector table, hand-written corner sequences,
// then random traffic against a queue-based reference model.
module tb_fetch_ctrl;

  localparam logic [31:0] IMB = 32'h0000_3000;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        Im_En_Out;
  logic [11:0] Im_Addr_Out;
  logic [31:0] Im_Instr_In = 32'h0;
  logic [31:0] Instr_Out;
  logic [31:0] Pc_Out;
  logic        Instr_Valid_Out;
  logic        Dec_Ready_In = 1'b1;
  logic        Redirect_In = 1'b0;
  logic [31:0] Redirect_Pc_In = 32'h0;
  logic        Exc_Out;

  always #5 Clk = ~Clk;

  fetch_ctrl dut (
    .Clk             (Clk),
    .Reset           (Reset),
    .Im_En_Out       (Im_En_Out),
    .Im_Addr_Out     (Im_Addr_Out),
    .Im_Instr_In     (Im_Instr_In),
    .Instr_Out       (Instr_Out),
    .Pc_Out          (Pc_Out),
    .Instr_Valid_Out (Instr_Valid_Out),
    .Dec_Ready_In    (Dec_Ready_In),
    .Redirect_In     (Redirect_In),
    .Redirect_Pc_In  (Redirect_Pc_In),
    .Exc_Out         (Exc_Out)
  );

  // Instruction memory: word k holds 0x1000_0000+k; garbage when not read.
  always @(posedge Clk)
    Im_Instr_In <= Im_En_Out ? (32'h1000_0000 + {20'h0, Im_Addr_Out}) : 32'hDEAD_BEEF;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        exc;
  } ent_t;

  ent_t        mq[$];
  logic [31:0] m_pc, m_inf_pc;
  logic        m_inf, m_inf_exc, m_halt;
  logic        m_pop, m_issue, m_bad;
  logic [31:0] dl[$];
  logic        seen_exc;
  int          en_seen;

  function automatic logic [11:0] idx(input logic [31:0] pc);
    logic [31:0] o;
    o = pc - IMB;
    return o[13:2];
  endfunction

  function automatic logic [31:0] word(input logic [31:0] pc);
    return 32'h1000_0000 + {20'h0, idx(pc)};
  endfunction

  task automatic model_eval();
    logic vld;
    vld   = (mq.size() != 0);
    m_pop = vld && Dec_Ready_In;
`ifdef FETCH_CTRL_ADDR_EXC_EN
    m_bad = (m_pc[1:0] != 2'b00) || ((m_pc - IMB) >= 32'h4000);
`else
    m_bad = 1'b0;
`endif
    m_issue = !Reset && !Redirect_In && !m_halt &&
              ((mq.size() + int'(m_inf) - int'(m_pop)) < 2);
    chk("valid", Instr_Valid_Out, vld);
    chk("im_en", Im_En_Out, m_issue && !m_bad);
    if (m_issue && !m_bad) chk("im_addr", Im_Addr_Out, idx(m_pc));
    if (vld) begin
      chk("pc", Pc_Out, mq[0].pc);
      chk("instr", Instr_Out, mq[0].instr);
      chk("exc", Exc_Out, mq[0].exc);
    end
    if (Instr_Valid_Out && Dec_Ready_In) dl.push_back(Pc_Out);
    if (Instr_Valid_Out && Exc_Out && Pc_Out == 32'h3102 && Instr_Out == 32'h0) seen_exc = 1'b1;
    if (Im_En_Out) en_seen++;
  endtask

  task automatic model_update();
    if (Reset) begin
      mq.delete();
      m_pc = IMB; m_inf = 0; m_inf_exc = 0; m_halt = 0;
    end else if (Redirect_In) begin
      mq.delete();
      m_pc = Redirect_Pc_In; m_inf = 0; m_inf_exc = 0; m_halt = 0;
    end else begin
      if (m_pop) void'(mq.pop_front());
      if (m_inf) mq.push_back('{m_inf_pc, (m_inf_exc ? 32'h0 : word(m_inf_pc)), m_inf_exc});
      m_inf = m_issue;
      if (m_issue) begin
        m_inf_pc  = m_pc;
        m_inf_exc = m_bad;
        m_pc      = m_pc + 32'd4;
        if (m_bad) m_halt = 1'b1;
      end
    end
  endtask

  task automatic cyc(input logic rst, input logic rdy, input logic rdr, input logic [31:0] rpc);
    Reset = rst; Dec_Ready_In = rdy; Redirect_In = rdr; Redirect_Pc_In = rpc;
    @(negedge Clk);
    model_eval();
    @(posedge Clk);
    model_update();
    #1;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        rst, rdy, rdr;
    logic [31:0] rpc;
    logic        e_en;
    logic [11:0] e_addr;
    logic        e_vld;
    logic [31:0] e_pc, e_instr;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(input logic rst, rdy, rdr, input logic [31:0] rpc,
                             input logic e_en, input logic [11:0] e_addr,
                             input logic e_vld, input logic [31:0] e_pc, e_instr);
    return '{rst, rdy, rdr, rpc, e_en, e_addr, e_vld, e_pc, e_instr};
  endfunction

  initial begin
    // reset held 3 cycles, startup stream
    for (int i = 0; i < 3; i++) tbl.push_back(v(1, 1, 0, 0, 0, 12'h0, 0, 0, 0));
    tbl.push_back(v(0, 1, 0, 0, 1, 12'h0, 0, 0, 0));
    tbl.push_back(v(0, 1, 0, 0, 1, 12'h1, 0, 0, 0));
    tbl.push_back(v(0, 1, 0, 0, 1, 12'h2, 1, 32'h3000, 32'h1000_0000));
    tbl.push_back(v(0, 1, 0, 0, 1, 12'h3, 1, 32'h3004, 32'h1000_0001));
    tbl.push_back(v(0, 1, 0, 0, 1, 12'h4, 1, 32'h3008, 32'h1000_0002));
    // decode stalls 6 cycles: head holds, fetch stops
    for (int i = 0; i < 6; i++) tbl.push_back(v(0, 0, 0, 0, 0, 12'h0, 1, 32'h300C, 32'h1000_0003));
    tbl.push_back(v(0, 1, 0, 0, 1, 12'h5, 1, 32'h300C, 32'h1000_0003));
    tbl.push_back(v(0, 1, 0, 0, 1, 12'h6, 1, 32'h3010, 32'h1000_0004));
    // fill the queue, then redirect to 0x3100
    tbl.push_back(v(0, 0, 0, 0, 0, 12'h0, 1, 32'h3014, 32'h1000_0005));
    tbl.push_back(v(0, 0, 1, 32'h3100, 0, 12'h0, 1, 32'h3014, 32'h1000_0005));
    tbl.push_back(v(0, 1, 0, 0, 1, 12'h40, 0, 0, 0));
    tbl.push_back(v(0, 1, 0, 0, 1, 12'h41, 0, 0, 0));
    tbl.push_back(v(0, 1, 0, 0, 1, 12'h42, 1, 32'h3100, 32'h1000_0040));
    tbl.push_back(v(0, 1, 0, 0, 1, 12'h43, 1, 32'h3104, 32'h1000_0041));

    // initial reset edge so the table starts from a known state
    Reset = 1'b1;
    @(posedge Clk);
    model_update();
    #1;

    foreach (tbl[i]) begin
      Reset = tbl[i].rst; Dec_Ready_In = tbl[i].rdy;
      Redirect_In = tbl[i].rdr; Redirect_Pc_In = tbl[i].rpc;
      @(negedge Clk);
      model_eval();
      chk($sformatf("tbl%0d_en", i), Im_En_Out, tbl[i].e_en);
      chk($sformatf("tbl%0d_vld", i), Instr_Valid_Out, tbl[i].e_vld);
      if (tbl[i].e_en || tbl[i].rst) chk($sformatf("tbl%0d_addr", i), Im_Addr_Out, tbl[i].e_addr);
      if (tbl[i].e_vld || tbl[i].rst) begin
        chk($sformatf("tbl%0d_pc", i), Pc_Out, tbl[i].e_pc);
        chk($sformatf("tbl%0d_instr", i), Instr_Out, tbl[i].e_instr);
        chk($sformatf("tbl%0d_exc", i), Exc_Out, 1'b0);
      end
      @(posedge Clk);
      model_update();
      #1;
    end

    // redirect coinciding with a pop of 0x3008, then a second redirect
    cyc(1, 1, 0, 0);
    dl.delete();
    for (int i = 0; i < 4; i++) cyc(0, 1, 0, 0);
    cyc(0, 1, 1, 32'h3180);
    cyc(0, 1, 1, 32'h3200);
    for (int i = 0; i < 5; i++) cyc(0, 1, 0, 0);
    chk("redir_dl_len", 32'(dl.size() >= 4), 32'd1);
    if (dl.size() >= 4) begin
      chk("redir_dl0", dl[0], 32'h3000);
      chk("redir_dl1", dl[1], 32'h3004);
      chk("redir_dl2", dl[2], 32'h3008);
      chk("redir_dl3", dl[3], 32'h3200);
    end

    // reset for one cycle with a read in flight
    for (int i = 0; i < 3; i++) cyc(0, 1, 0, 0);
    cyc(1, 1, 0, 0);
    dl.delete();
    Reset = 1'b0;
    #1;
    chk("rst_mid_valid", Instr_Valid_Out, 1'b0);
    chk("rst_mid_addr", Im_Addr_Out, 32'h0);
    for (int i = 0; i < 4; i++) cyc(0, 1, 0, 0);
    chk("rst_mid_dl_len", 32'(dl.size() >= 1), 32'd1);
    if (dl.size() >= 1) chk("rst_mid_first_pc", dl[0], 32'h3000);

    // misaligned redirect target
    cyc(0, 1, 1, 32'h3102);
`ifdef FETCH_CTRL_ADDR_EXC_EN
    seen_exc = 1'b0;
    en_seen  = 0;
    for (int i = 0; i < 6; i++) cyc(0, 1, 0, 0);
    chk("exc_entry_seen", seen_exc, 1'b1);
    chk("exc_no_strobe", en_seen, 32'd0);
    cyc(0, 1, 1, 32'h3000);
    dl.delete();
    for (int i = 0; i < 4; i++) cyc(0, 1, 0, 0);
    chk("exc_resume_len", 32'(dl.size() >= 1), 32'd1);
    if (dl.size() >= 1) chk("exc_resume_pc", dl[0], 32'h3000);
`else
    dl.delete();
    Redirect_In = 1'b0;
    #1;
    chk("unal_addr", Im_Addr_Out, 32'h40);
    chk("unal_en", Im_En_Out, 1'b1);
    for (int i = 0; i < 4; i++) cyc(0, 1, 0, 0);
    chk("unal_exc", Exc_Out, 1'b0);
    chk("unal_dl_len", 32'(dl.size() >= 1), 32'd1);
    if (dl.size() >= 1) chk("unal_pc", dl[0], 32'h3102);
`endif

    // random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      logic        r_rst, r_rdy, r_rdr;
      logic [31:0] r_pc;
      r_rst = ($urandom_range(0, 199) == 0);
      r_rdr = ($urandom_range(0, 24) == 0);
      r_rdy = ($urandom_range(0, 9) < 7);
      r_pc  = ($urandom_range(0, 15) == 0) ? $urandom : (IMB + 32'(4 * $urandom_range(0, 4095)));
      cyc(r_rst, r_rdy, r_rdr, r_pc);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
